eth_tx_frame_arbiter: RTL

Round-robin frame arbiter that shares the single 32-bit Ethernet transmit datapath between SOURCE_NUMBER frame sources. It grants one source for a whole frame, from first word to end-of-packet. While granted, it muxes that source's data, byte-enable and handshake onto the transmitter interface. It then enforces a programmable inter-frame idle gap and guards against runaway frames with a word-count limit.

---
 rtl/eth_pkg.sv | 30 +++
 rtl/eth_rr_pick.sv | 33 +++
 rtl/eth_tx_frame_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet MAC transmit-side schedulers.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Byte count of an eop word; non-eop words always carry 4 bytes.
  typedef enum logic [1:0] {
    BE_4B = 2'b00,
    BE_1B = 2'b01,
    BE_2B = 2'b10,
    BE_3B = 2'b11
  } be_e;

  localparam int DATA_W = 32;
  localparam int BE_W   = 2;

  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module eth_rr_pick
  import eth_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [PW-1:0] next_ptr_o,
  output logic          any_o
);

  int idx;

  always_comb begin
    pick_o     = '0;
    next_ptr_o = ptr_i;
    any_o      = |req_i;
    idx        = 0;
    // Scan farthest offset first so the nearest requester is the last to win.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        pick_o      = '0;
        pick_o[idx] = 1'b1;
        next_ptr_o  = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter onto the 32-bit transmit datapath,
// with inter-frame gap enforcement and a runaway-frame word limit.
module eth_tx_frame_arbiter
  import eth_pkg::*;
#(
  parameter int SOURCE_NUMBER   = 2,
  parameter int IFG_CYCLES      = 3,
  parameter int MAX_FRAME_WORDS = 380
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [SOURCE_NUMBER-1:0]        req_in,
  input  logic [SOURCE_NUMBER-1:0]        rdy_in,
  input  logic [SOURCE_NUMBER*DATA_W-1:0] dat_in,
  input  logic [SOURCE_NUMBER*BE_W-1:0]   be_in,
  input  logic [SOURCE_NUMBER-1:0]        eop_in,
  output logic [SOURCE_NUMBER-1:0]        ack_out,
  output logic [SOURCE_NUMBER-1:0]        gnt_out,
  output logic                            tx_rdy_out,
  output logic [DATA_W-1:0]               tx_dat_out,
  output logic [BE_W-1:0]                 tx_be_out,
  output logic                            tx_sop_out,
  output logic                            tx_eop_out,
  output logic                            tx_abort_out,
  input  logic                            tx_ack_in
);

  localparam int N  = SOURCE_NUMBER;
  localparam int PW = clog2_min1(N);
  localparam int WW = clog2_min1(MAX_FRAME_WORDS);
  localparam int GW = clog2_min1(IFG_CYCLES);
  localparam logic [WW-1:0] WCNT_LAST = WW'(MAX_FRAME_WORDS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IFG_CYCLES - 1);

  state_e          state_q;
  logic [N-1:0]    gnt_q;
  logic [PW-1:0]   ptr_q;
  logic [WW-1:0]   wcnt_q;
  logic [GW-1:0]   gap_q;
  logic            abort_q;

  logic [N-1:0]    pick;
  logic [PW-1:0]   next_ptr;
  logic            pick_any;

  eth_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req_i      (req_in),
    .ptr_i      (ptr_q),
    .pick_o     (pick),
    .next_ptr_o (next_ptr),
    .any_o      (pick_any)
  );

  // Grant is one-hot, so masking every source and OR-reducing yields the mux.
  logic [N-1:0][DATA_W-1:0] dat_m;
  logic [N-1:0][BE_W-1:0]   be_m;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mux
      assign dat_m[gi] = gnt_q[gi] ? dat_in[gi*DATA_W +: DATA_W] : '0;
      assign be_m[gi]  = gnt_q[gi] ? be_in[gi*BE_W +: BE_W] : '0;
    end
  endgenerate

  logic [DATA_W-1:0] sel_dat;
  logic [BE_W-1:0]   sel_be;
  logic              sel_rdy;
  logic              sel_eop;
  logic              in_xfer;
  logic              word_xfer;
  logic              last_word;

  always_comb begin
    sel_dat = '0;
    sel_be  = '0;
    for (int i = 0; i < N; i++) begin
      sel_dat = sel_dat | dat_m[i];
      sel_be  = sel_be | be_m[i];
    end
  end

  assign sel_rdy   = |(gnt_q & rdy_in);
  assign sel_eop   = |(gnt_q & eop_in);
  assign in_xfer   = (state_q == ST_XFER);
  assign word_xfer = in_xfer && sel_rdy && tx_ack_in;
  assign last_word = (wcnt_q == WCNT_LAST);

  always_comb begin
    tx_rdy_out = 1'b0;
    tx_dat_out = '0;
    tx_be_out  = BE_4B;
    tx_sop_out = 1'b0;
    tx_eop_out = 1'b0;
    ack_out    = '0;
    if (in_xfer) begin
      tx_rdy_out = sel_rdy;
      tx_dat_out = sel_dat;
      tx_be_out  = sel_be;
      tx_sop_out = sel_rdy && (wcnt_q == '0);
      // A word at the limit is forced to close the frame even without source eop.
      tx_eop_out = sel_eop || (sel_rdy && last_word);
      ack_out    = tx_ack_in ? (gnt_q & rdy_in) : '0;
    end
  end

  assign gnt_out      = gnt_q;
  assign tx_abort_out = abort_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_q   <= pick;
            ptr_q   <= next_ptr;
            wcnt_q  <= '0;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (word_xfer) begin
            if (sel_eop || last_word) begin
              gnt_q   <= '0;
              wcnt_q  <= '0;
              gap_q   <= '0;
              abort_q <= !sel_eop;
              state_q <= (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
